// File: rtl/reg_sequencer.sv
// reg_sequencer: turns 8-bit micro-instructions into single-cycle control pulses
// for the 4-bit register and drives the ALU opcode/operands with result write-back.
module reg_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic       done,
    output logic       illegal,
    input  logic [3:0] reg_out,
    input  logic [3:0] alu_f,
    output logic [2:0] alu_oc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       ld,
    output logic       inc,
    output logic       cl,
    output logic       dec,
    output logic       sr,
    output logic       ir,
    output logic       sl,
    output logic       il,
    output logic [3:0] reg_in
);
    typedef enum logic [1:0] {IDLE, EXEC, WB, FIN} state_t;

    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_CLR = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_ALU = 4'd7;
    localparam logic [3:0] OP_LDB = 4'd8;
    localparam logic [3:0] OP_REP = 4'd9;

    state_t     state;
    logic [3:0] op_q;
    logic [3:0] imm_q;
    logic [3:0] cnt;
    logic [3:0] b_reg;
    logic [3:0] res_q;
    logic [3:0] ldi_q;
    logic [3:0] op_in;
    logic [3:0] imm_in;

    assign op_in       = instr[7:4];
    assign imm_in      = instr[3:0];
    assign instr_ready = (state == IDLE);
    assign alu_a       = reg_out;
    assign alu_b       = b_reg;
    // Load data is the immediate for LDI and the captured ALU result in write-back.
    assign reg_in      = (state == WB) ? res_q : ldi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            imm_q   <= '0;
            cnt     <= '0;
            b_reg   <= '0;
            res_q   <= '0;
            ldi_q   <= '0;
            alu_oc  <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            {ld, inc, cl, dec, sr, ir, sl, il} <= '0;
        end else begin
            {ld, inc, cl, dec, sr, ir, sl, il} <= '0;
            ldi_q   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    state <= EXEC;
                    op_q  <= op_in;
                    imm_q <= imm_in;
                    cnt   <= imm_in;
                    if (op_in == OP_ALU) alu_oc <= imm_in[2:0];
                    // Pulses launch at acceptance so the register samples them one edge later.
                    ld    <= (op_in == OP_LDI);
                    ldi_q <= (op_in == OP_LDI) ? imm_in : 4'd0;
                    cl    <= (op_in == OP_CLR);
                    inc   <= (op_in == OP_INC) || (op_in == OP_REP && imm_in != 4'd0);
                    dec   <= (op_in == OP_DEC);
                    sr    <= (op_in == OP_SHR);
                    ir    <= (op_in == OP_SHR) && imm_in[0];
                    sl    <= (op_in == OP_SHL);
                    il    <= (op_in == OP_SHL) && imm_in[0];
                end
                EXEC: if (op_q == OP_REP && cnt > 4'd1) begin
                    cnt <= cnt - 4'd1;
                    inc <= 1'b1;
                end else if (op_q == OP_ALU) begin
                    res_q <= alu_f;
                    ld    <= 1'b1;
                    state <= WB;
                end else begin
                    if (op_q == OP_LDB) b_reg <= imm_q;
                    cnt     <= '0;
                    done    <= 1'b1;
                    illegal <= (op_q >= 4'd10);
                    state   <= FIN;
                end
                WB: begin
                    done  <= 1'b1;
                    state <= FIN;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_sequencer.sv
// tb_reg_sequencer: drives reg_sequencer against a behavioural register/ALU and
// checks each cycle against traces derived from the instruction semantics.
module tb_reg_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_ready, done, illegal;
    logic [3:0] reg_out, alu_f, alu_a, alu_b, reg_in;
    logic [2:0] alu_oc;
    logic       ld, inc, cl, dec, sr, ir, sl, il;
    logic [3:0] r = 4'd0;
    logic [3:0] m_reg = 4'd0;
    logic [3:0] m_b = 4'd0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [13:0] obs_v;

    always #5 clk = ~clk;

    reg_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .done(done), .illegal(illegal),
        .reg_out(reg_out), .alu_f(alu_f), .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b),
        .ld(ld), .inc(inc), .cl(cl), .dec(dec), .sr(sr), .ir(ir), .sl(sl), .il(il),
        .reg_in(reg_in)
    );

    function automatic logic [3:0] alu_fn(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        case (oc)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a;
            default: return b;
        endcase
    endfunction

    function automatic logic [13:0] ev(input logic d, input logic x, input logic [7:0] c, input logic [3:0] v);
        return {d, x, c, v};
    endfunction

    // The 4-bit register being sequenced; it has no reset of its own.
    always @(posedge clk)
        r <= ld ? reg_in : cl ? 4'd0 : inc ? r + 4'd1 : dec ? r - 4'd1 :
             sr ? {ir, r[3:1]} : sl ? {r[2:0], il} : r;

    assign reg_out = r;
    assign alu_f   = alu_fn(alu_oc, alu_a, alu_b);
    assign obs_v   = {done, illegal, ld, inc, cl, dec, sr, ir, sl, il, reg_in};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] imm,
                             input logic hold_valid = 1'b0, input logic [7:0] hold_instr = 8'h00);
        logic [13:0] tr[$];
        logic [3:0]  nr, nb;
        int          waits;
        nr = m_reg;
        nb = m_b;
        case (op)
            4'd0: tr.push_back(14'd0);
            4'd1: begin tr.push_back(ev(0, 0, 8'h80, imm)); nr = imm; end
            4'd2: begin tr.push_back(ev(0, 0, 8'h20, 0)); nr = 4'd0; end
            4'd3: begin tr.push_back(ev(0, 0, 8'h40, 0)); nr = m_reg + 4'd1; end
            4'd4: begin tr.push_back(ev(0, 0, 8'h10, 0)); nr = m_reg - 4'd1; end
            4'd5: begin tr.push_back(ev(0, 0, imm[0] ? 8'h0C : 8'h08, 0)); nr = {imm[0], m_reg[3:1]}; end
            4'd6: begin tr.push_back(ev(0, 0, imm[0] ? 8'h03 : 8'h02, 0)); nr = {m_reg[2:0], imm[0]}; end
            4'd7: begin
                nr = alu_fn(imm[2:0], m_reg, m_b);
                tr.push_back(14'd0);
                tr.push_back(ev(0, 0, 8'h80, nr));
            end
            4'd8: begin tr.push_back(14'd0); nb = imm; end
            4'd9: begin
                if (imm == 4'd0) tr.push_back(14'd0);
                else repeat (int'(imm)) tr.push_back(ev(0, 0, 8'h40, 0));
                nr = m_reg + imm;
            end
            default: tr.push_back(14'd0);
        endcase
        tr.push_back(ev(1, op >= 4'd10, 8'h00, 0));
        instr_valid = 1'b1;
        instr = {op, imm};
        waits = 0;
        while (!instr_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        check("accept_wait", waits < 40, 1);
        @(negedge clk);
        instr_valid = hold_valid;
        instr = hold_instr;
        foreach (tr[i]) begin
            check($sformatf("op%0d_imm%0d_cyc%0d", op, imm, i), obs_v, tr[i]);
            check("busy_ready", instr_ready, 0);
            check("onehot", $onehot0({ld, inc, cl, dec, sr, sl}), 1);
            if (op == 4'd7 && i == 0) begin
                check("alu_a", alu_a, m_reg);
                check("alu_b", alu_b, m_b);
                check("alu_oc", alu_oc, imm[2:0]);
            end
            @(negedge clk);
        end
        check("idle_ready", instr_ready, 1);
        check("idle_quiet", obs_v, 0);
        m_reg = nr;
        m_b = nb;
        check("reg_value", r, m_reg);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_quiet", obs_v, 0);
        check("rst_alu_oc", alu_oc, 0);
        check("rst_alu_b", alu_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(4'd1, 4'hA);
        check("basic_ldi", r, 10);
        run_instr(4'd6, 4'd1);
        check("basic_shl", r, 5);
        run_instr(4'd5, 4'd0);
        check("basic_shr", r, 2);

        run_instr(4'd1, 4'd6);
        run_instr(4'd8, 4'd3);
        run_instr(4'd7, 4'd0);
        check("alu_add", r, 9);
        run_instr(4'd7, 4'd1);
        check("alu_sub", r, 6);

        run_instr(4'd9, 4'd0);
        run_instr(4'd1, 4'd3);
        run_instr(4'd9, 4'd15);
        check("rep15_wrap", r, 2);

        run_instr(4'd9, 4'd5, 1'b1, 8'hC0);
        run_instr(4'hC, 4'd0);

        run_instr(4'd1, 4'd4);
        instr_valid = 1'b1;
        instr = 8'h99;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rep_pre_reset_inc", inc, 1);
            if (i < 2) @(negedge clk);
            else @(posedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ready", instr_ready, 1);
        check("async_rst_quiet", obs_v, 0);
        check("async_rst_alu_oc", alu_oc, 0);
        check("async_rst_alu_b", alu_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_quiet", obs_v, 0);
        end
        check("post_rst_reg", r, 7);
        m_reg = 4'd7;
        m_b = 4'd0;

        for (int n = 0; n < 1000; n++) begin
            run_instr(4'($urandom_range(0, 15)), 4'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("gap_quiet", obs_v, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
